// File: rtl/scan_decoder_if.sv
// scan_decoder_if: control/status bundle for scan_decoder.
//   master: drives en, mode, start, abort, in, last, dwell;
//           observes out, idx, busy, done.
//   slave : the decoder side (mirror of master).
// SEL_W   select width, out is 2**SEL_W bits wide.
// DWELL_W width of the per-step dwell count.
interface scan_decoder_if #(
  parameter int unsigned SEL_W   = 6,
  parameter int unsigned DWELL_W = 4
);
  logic                  en;
  logic                  mode;
  logic                  start;
  logic                  abort;
  logic [SEL_W-1:0]      in;
  logic [SEL_W-1:0]      last;
  logic [DWELL_W-1:0]    dwell;
  logic [(2**SEL_W)-1:0] out;
  logic [SEL_W-1:0]      idx;
  logic                  busy;
  logic                  done;

  modport master (
    output en, mode, start, abort, in, last, dwell,
    input  out, idx, busy, done
  );

  modport slave (
    input  en, mode, start, abort, in, last, dwell,
    output out, idx, busy, done
  );
endinterface

// File: rtl/scan_decoder.sv
// scan_decoder: registered binary-to-one-hot decoder with a scan sequencer.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    scan_decoder_if.slave
//     en     output enable / scan-advance enable
//     mode   0 = direct decode, 1 = scan (sampled in IDLE)
//     start  scan launch (IDLE, mode=1 only)
//     abort  terminate scan, no done
//     in     direct select / scan start index
//     last   scan end index (latched at start)
//     dwell  cycles per step minus 1 (latched at start)
//     out    registered one-hot select or zero
//     idx    current index register
//     busy   high while scanning
//     done   one-cycle pulse on scan completion
module scan_decoder #(
  parameter int unsigned SEL_W   = 6,
  parameter int unsigned DWELL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  scan_decoder_if.slave    bus
);

  localparam int unsigned N = 2**SEL_W;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [SEL_W-1:0]     last_q, last_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]         out_q, out_d;
  logic                 done_q, done_d;
  logic [SEL_W-1:0]     idx_inc;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [N-1:0] r;
    r    = '0;
    r[s] = 1'b1;
    return r;
  endfunction

  // Natural SEL_W-bit overflow gives the wrap from 2**SEL_W-1 to 0.
  assign idx_inc = idx_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    out_d   = '0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.mode) begin
          idx_d = bus.in;
          out_d = bus.en ? onehot(bus.in) : '0;
        end else if (bus.start) begin
          idx_d   = bus.in;
          last_d  = bus.last;
          dwell_d = bus.dwell;
          cnt_d   = bus.dwell;
          state_d = SCAN;
          out_d   = bus.en ? onehot(bus.in) : '0;
        end
      end
      SCAN: begin
        // Priority order matters: abort beats pause beats the final step.
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!bus.en) begin
          out_d = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          out_d = onehot(idx_q);
        end else if (idx_q == last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_inc;
          cnt_d = dwell_q;
          out_d = onehot(idx_inc);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.busy = (state_q == SCAN);
  assign bus.done = done_q;

endmodule

// File: tb/tb_scan_decoder.sv
module tb_scan_decoder;

  logic clk;
  logic rst_n;
  int unsigned tests;
  int unsigned failed;

  scan_decoder_if #(.SEL_W(6), .DWELL_W(4)) bus ();

  scan_decoder #(.SEL_W(6), .DWELL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Checks out == bit b, busy, done in one go.
  task automatic chk_scan(input string tag, input int b, input logic bsy, input logic dn);
    chk({tag, ".out"}, bus.out, (b < 0) ? 64'd0 : (64'd1 << b));
    chk({tag, ".busy"}, 64'(bus.busy), 64'(bsy));
    chk({tag, ".done"}, 64'(bus.done), 64'(dn));
  endtask

  int exp_basic[6] = '{3, 3, 4, 4, 5, 5};
  int exp_wrap[4]  = '{62, 63, 0, 1};

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    bus.en = 1'b0; bus.mode = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.in = '0; bus.last = '0; bus.dwell = '0;

    // Reset state
    #3;
    chk("rst.out", bus.out, 64'd0);
    chk("rst.idx", 64'(bus.idx), 64'd0);
    chk_scan("rst", -1, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;

    // Direct decode
    bus.en = 1'b1; bus.in = 6'h2A;
    tick();
    chk("dir42.out", bus.out, 64'h0000_0400_0000_0000);
    chk("dir42.idx", 64'(bus.idx), 64'd42);
    bus.en = 1'b0;
    tick();
    chk("dir_en0.out", bus.out, 64'd0);
    chk("dir_en0.idx", 64'(bus.idx), 64'd42);
    bus.en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.in = 6'(i);
      tick();
      chk("sweep.out", bus.out, 64'd1 << i);
      chk("sweep.ones", 64'($countones(bus.out)), 64'd1);
    end

    // Basic scan 3..5, dwell 1
    bus.mode = 1'b1; bus.in = 6'd3; bus.last = 6'd5; bus.dwell = 4'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.in = 6'd50; bus.last = 6'd9; bus.dwell = 4'd7;
    for (int k = 0; k < 6; k++) begin
      chk_scan("basic", exp_basic[k], 1'b1, 1'b0);
      tick();
    end
    chk_scan("basic.end", -1, 1'b0, 1'b1);
    chk("basic.idx", 64'(bus.idx), 64'd5);
    tick();
    chk_scan("basic.after", -1, 1'b0, 1'b0);

    // Wrap scan 62..1, dwell 0
    bus.in = 6'd62; bus.last = 6'd1; bus.dwell = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_scan("wrap", exp_wrap[k], 1'b1, 1'b0);
      tick();
    end
    chk_scan("wrap.end", -1, 1'b0, 1'b1);

    // Start on the edge right after done: single-step scan at 9
    bus.in = 6'd9; bus.last = 6'd9; bus.dwell = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_scan("single", 9, 1'b1, 1'b0);
    tick();
    chk_scan("single.end", -1, 1'b0, 1'b1);

    // Pause: scan 3..6 dwell 2, drop en at idx 4
    bus.in = 6'd3; bus.last = 6'd6; bus.dwell = 4'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk_scan("pause.pre", 4, 1'b1, 1'b0);
    chk("pause.pre.idx", 64'(bus.idx), 64'd4);
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_scan("pause", -1, 1'b1, 1'b0);
      chk("pause.idx", 64'(bus.idx), 64'd4);
    end
    bus.en = 1'b1;
    tick();
    chk_scan("resume1", 4, 1'b1, 1'b0);
    tick();
    chk_scan("resume2", 4, 1'b1, 1'b0);
    tick();
    chk_scan("resume3", 5, 1'b1, 1'b0);
    // Abort mid-scan
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_scan("abort", -1, 1'b0, 1'b0);
    chk("abort.idx", 64'(bus.idx), 64'd5);
    tick();
    chk_scan("abort.after", -1, 1'b0, 1'b0);

    // Async reset mid-scan
    bus.in = 6'd10; bus.last = 6'd20; bus.dwell = 4'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk_scan("prerst", 10, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_scan("asyncrst", -1, 1'b0, 1'b0);
    chk("asyncrst.idx", 64'(bus.idx), 64'd0);
    tick();
    rst_n = 1'b1;
    chk_scan("rst.hold", -1, 1'b0, 1'b0);

    // start with mode=0: direct decode, no scan
    bus.mode = 1'b0; bus.start = 1'b1; bus.in = 6'd7;
    tick();
    bus.start = 1'b0;
    chk_scan("nomode", 7, 1'b0, 1'b0);

    // start held during SCAN is ignored
    bus.mode = 1'b1; bus.in = 6'd0; bus.last = 6'd1; bus.dwell = 4'd0; bus.start = 1'b1;
    tick();
    bus.in = 6'd40;
    chk_scan("ign0", 0, 1'b1, 1'b0);
    tick();
    bus.start = 1'b0;
    chk_scan("ign1", 1, 1'b1, 1'b0);
    tick();
    chk_scan("ign.end", -1, 1'b0, 1'b1);
    chk("ign.idx", 64'(bus.idx), 64'd1);

    // abort coincident with final step
    bus.in = 6'd5; bus.last = 6'd6; bus.dwell = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_scan("fin5", 5, 1'b1, 1'b0);
    tick();
    chk_scan("fin6", 6, 1'b1, 1'b0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_scan("fin.abort", -1, 1'b0, 1'b0);
    tick();
    chk_scan("fin.after", -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Parametrised, registered binary-to-one-hot decoder with a built-in scan sequencer. It generalises the fixed 6-to-64 enable-gated decoder to any select width. It adds two modes:
- Direct mode: one-hot decode of `in`, registered, latency 1.
- Scan mode: steps the active output through an index range, holding each line for a programmable number of cycles, then pulses `done`.

Intended for row/bank select and scanned-display drivers.

## Interface
Parameters:
- `SEL_W`, default 6: select width; output width is 2^SEL_W.
- `DWELL_W`, default 4: width of the dwell-count input.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  output enable and scan-advance enable.
- `mode`  in  1  0 = direct decode, 1 = scan; sampled only in IDLE.
- `start`  in  1  scan launch; acted on only in IDLE with `mode`=1.
- `abort`  in  1  terminates a scan; ignored in IDLE.
- `in`  in  SEL_W  direct-mode select; scan start index.
- `last`  in  SEL_W  scan end index; sampled at `start`.
- `dwell`  in  DWELL_W  cycles per step minus 1; sampled at `start`.
- `out`  out  2^SEL_W  registered one-hot select, or all zero.
- `idx`  out  SEL_W  current index register.
- `busy`  out  1  high while in SCAN.
- `done`  out  1  one-cycle pulse on scan completion.

## Operation
Reset (async, `rst_n`=0): state IDLE; `out`=0, `idx`=0, `busy`=0, `done`=0; internal `last` and `dwell` registers and dwell counter all 0. Effect is immediate, including mid-scan. No `done` is produced by a reset.

States: IDLE, SCAN. `busy` = (state==SCAN).

IDLE, `mode`=0 (direct), each edge:
- `idx` <= `in`.
- `out` <= `en` ? (1 << `in`) : 0.
- Identical to the predecessor decoder, but registered.
- `start` is ignored.

IDLE, `mode`=1:
- Without `start`: `out` <= 0 and `idx` holds.
- With `start`=1: `idx` <= `in`; latch `last` and `dwell`; dwell counter <= `dwell`; state <= SCAN; `out` <= `en` ? (1 << `in`) : 0.

SCAN, each edge, first match wins:
1. `abort`=1: state <= IDLE; `out` <= 0; `done` stays 0; `idx` holds.
2. `en`=0: `out` <= 0; `idx` and dwell counter frozen (pause).
3. Dwell counter != 0: decrement; `out` <= 1 << `idx`.
4. Dwell counter == 0 and `idx` == latched `last`: state <= IDLE; `out` <= 0; `done` <= 1 for one cycle.
5. Otherwise: `idx` <= `idx`+1 modulo 2^SEL_W; dwell counter <= latched `dwell`; `out` <= 1 << (`idx`+1).

Rules and boundaries:
- `start`, `mode`, `in`, `last` and `dwell` changes during SCAN are ignored.
- `last` < start index: the scan wraps through 2^SEL_W−1 to 0, then continues to `last`.
- `in` == `last`: single-step scan.
- `dwell`=0: one cycle per index.
- `out` is never more than one-hot. It is 0 whenever `en` was low at the last edge.
- `abort` together with the final step: `abort` wins; no `done`.
- A new `start` may be accepted on the edge after `done` (IDLE one cycle).

## Timing
- Direct-mode latency: 1 cycle from `in`/`en` to `out`.
- Scan launch: `start` sampled at edge T; from T, `busy`=1 and `out`=1<<`in`.
- Each index is visible for exactly `dwell`+1 enabled cycles. Paused cycles (`en`=0) add to this with `out`=0.
- Scan of K indices with `en` held high: `busy` for K·(`dwell`+1) cycles. `done` is high in the cycle after the last index's final cycle, coincident with `busy`=0 and `out`=0.
- `abort` at edge A: `out`=0 and `busy`=0 from A.

## Test plan
- Direct decode, SEL_W=6:
  - `mode`=0, `en`=1, `in`=0x2A → next cycle `out`=1<<42, `idx`=42.
  - `en`=0 → `out`=0.
  - Sweep all 64 values; check exactly one bit is set.
- Basic scan: `in`=3, `last`=5, `dwell`=1, `en`=1, pulse `start` → `out` = bit3, bit3, bit4, bit4, bit5, bit5, then 0. `done` is high for 1 cycle; `busy` is high for 6 cycles.
- Wrap scan: `in`=62, `last`=1, `dwell`=0 → `out` = bits 62, 63, 0, 1, then `done`.
- Pause and abort:
  - During scan, drop `en` for 3 cycles at `idx`=4 → `out`=0 and `idx` frozen. On resume, bit4 completes its remaining dwell.
  - Separately, `abort` mid-scan → `busy`=0 and `out`=0 next cycle; `done` never asserted.
- Reset and ignores:
  - Assert `rst_n`=0 asynchronously mid-scan → all outputs 0 without a clock edge.
  - Release, then issue `start` with `mode`=0 → no scan.
  - Issue `start` during SCAN → ignored.
  - `abort` coincident with the final step → no `done`.
